mostra_sequencia: RTL and testbench
===================================

# mostra_sequencia

Sequence presenter for the memory game: on `iniciar`, walks the sequence memory from address 0 up to `limite` and shows each stored 4-bit value on the LEDs for a fixed number of cycles, then pulses `pronto`. It is the output side of the button-compare datapath: it shows the player the sequence that the player is later required to repeat. It sits beside `fluxo_dados` and shares the sequence memory through an address/data pair.

## Interface
- `T_ON`, default 1000: clock cycles each value stays lit (≥1).
- `T_OFF`, default 500: blank cycles between values (≥1). Used only with `SEQ_GAP_EN`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces `inicial` and all outputs to their reset values.
- `iniciar` in 1: start request, sampled in `inicial` only.
- `limite` in 4: last address shown (inclusive); sampled when `iniciar` is accepted.
- `dado` in 4: memory data for `endereco`; synchronous-read memory with 1-cycle latency is allowed.
- `endereco` out 4: memory address; reset value 0.
- `leds` out 4: equals `dado` in `mostra`, otherwise 4'b0000; reset value 0.
- `exibindo` out 1: high in every state except `inicial`; reset value 0.
- `pronto` out 1: high only in `fim` (one cycle); reset value 0.
- `db_estado` out 4: state encoding, for the hex display; reset value 0.

## Operation
- States and encodings: `inicial`=0, `preparacao`=1, `mostra`=2, `apaga`=3, `proximo`=4, `fim`=5. Unused codes go to `inicial`.
- `inicial`: idle. `iniciar`=1 → `preparacao`; `limite` is latched into an internal register.
- `preparacao` (1 cycle): `endereco`←0, timer←0 → `mostra`.
- `mostra`: the timer counts from 0 to T_ON-1. On the last count: if `endereco` = latched limit → `fim`; otherwise → `apaga` (macro defined) or `proximo` (macro undefined). The timer clears on exit.
- `apaga`: `leds`=0 for T_OFF cycles → `proximo`.
- `proximo` (1 cycle): `endereco`←`endereco`+1, timer←0 → `mostra`. This gives the memory one cycle to settle before display.
- `fim` (1 cycle): `pronto`=1 → `inicial`. `endereco` holds its last value until the next `preparacao`.
- `iniciar` is ignored outside `inicial`. Changes to `limite` during a run have no effect.
- Timer width is $clog2(max(T_ON,T_OFF)+1). The counter saturates and never wraps mid-state.
- `endereco` never wraps. `limite`=15 shows 16 values and ends with `endereco`=15.

## Timing
- Cycle 0 is the edge that samples `iniciar`=1. `preparacao` runs in cycle 1, and `mostra` for address 0 runs in cycles 2..T_ON+1.
- No gap: `fim`/`pronto` occurs in cycle 2+(L+1)·T_ON+L.
- With gap: `fim`/`pronto` occurs in cycle 2+(L+1)·T_ON+L·(T_OFF+1).
- `leds` is combinational from the state and `dado`, so it changes in the same cycle the state enters or leaves `mostra`.
- `reset` asserted mid-run: outputs go to reset values immediately (no clock needed). Release resumes in `inicial`. A held `iniciar` starts a new run on the first edge after release.
- `iniciar` and `reset` both high: `reset` wins.

## Configuration
- `SEQ_GAP_EN` defined: the `apaga` state is compiled in, and a blank interval of T_OFF cycles separates consecutive values. Repeated equal values are visibly distinct.
- `SEQ_GAP_EN` undefined: `apaga` is absent, and `mostra` goes directly to `proximo`. Consecutive equal values appear as one lit period, apart from a one-cycle blank in `proximo`. Encoding 3 is unused and goes to `inicial`.

## Test plan
Benches use T_ON=3, T_OFF=2.
- No gap, L=0, mem[0]=0001, `iniciar` pulse at cycle 0 -> `leds`=0001 in cycles 2–4, `pronto`=1 only in cycle 5, `db_estado` sequence 1,2,2,2,5,0.
- Gap, L=3, mem=1,2,4,8 -> `leds` shows 1,0,2,0,4,0,8 with 3 lit cycles and 3 blank cycles (2 `apaga` + 1 `proximo`) between values. `pronto` in cycle 23.
- `iniciar` re-pulsed during `mostra`, and `limite` changed mid-run -> run is unaffected, only one `pronto`, shown count matches the latched limit.
- `reset` asserted asynchronously during `mostra` of address 2 -> `leds`=0, `endereco`=0, `exibindo`=0, `db_estado`=0 before the next edge. No `pronto`.
- No gap, L=15 -> 16 values shown, final `endereco`=15 with no wrap to 0, `pronto` in cycle 65.
- Synchronous-read memory model (1-cycle latency) -> every `mostra` period shows the correct mem[`endereco`] from its first cycle.

Source files
------------

// File: rtl/mostra_sequencia.sv
// -----------------------------------------------------------------------------
// mostra_sequencia
//
// Sequence presenter for the memory game. On 'iniciar' it walks the sequence
// memory from address 0 up to the latched 'limite' (inclusive), shows each
// stored 4-bit value on 'leds' for T_ON cycles, then pulses 'pronto' for one
// cycle and returns to idle.
//
// Configuration macro: SEQ_GAP_EN
//   defined   -> an 'apaga' state blanks the LEDs for T_OFF cycles between
//                consecutive values, so repeated equal values stay distinct.
//   undefined -> 'mostra' goes straight to 'proximo'; encoding 3 is unused.
//
// Parameters:
//   T_ON       cycles each value stays lit (>= 1)
//   T_OFF      blank cycles between values (>= 1), used only with SEQ_GAP_EN
//
// Ports:
//   clock      single clock, rising edge
//   reset      asynchronous, active-high; returns to 'inicial'
//   iniciar    start request, sampled only in 'inicial'
//   limite     last address shown, latched when 'iniciar' is accepted
//   dado       memory data for 'endereco' (synchronous read allowed)
//   endereco   memory address
//   leds       'dado' while in 'mostra', otherwise 0
//   exibindo   high in every state except 'inicial'
//   pronto     one-cycle completion pulse (state 'fim')
//   db_estado  state encoding for the debug hex display
// -----------------------------------------------------------------------------
module mostra_sequencia #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] TIMER_ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] TIMER_SAT      = TW'(T_MAX);
`ifdef SEQ_GAP_EN
  localparam logic [TW-1:0] TIMER_OFF_LAST = TW'(T_OFF - 1);
`endif

  typedef enum logic [3:0] {
    st_inicial    = 4'd0,
    st_preparacao = 4'd1,
    st_mostra     = 4'd2,
`ifdef SEQ_GAP_EN
    st_apaga      = 4'd3,
`endif
    st_proximo    = 4'd4,
    st_fim        = 4'd5
  } estado_t;

  estado_t       estado_reg;
  logic [3:0]    endereco_reg;
  logic [3:0]    limite_reg;
  logic [TW-1:0] timer_reg;

  // The address is updated on the edge that enters 'preparacao' / 'proximo',
  // so a synchronous-read memory has that whole cycle to present the new
  // word before 'mostra' starts displaying it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg   <= st_inicial;
      endereco_reg <= 4'd0;
      limite_reg   <= 4'd0;
      timer_reg    <= '0;
    end else begin
      case (estado_reg)
        st_inicial: begin
          if (iniciar) begin
            limite_reg   <= limite;
            endereco_reg <= 4'd0;
            timer_reg    <= '0;
            estado_reg   <= st_preparacao;
          end
        end

        st_preparacao: begin
          timer_reg  <= '0;
          estado_reg <= st_mostra;
        end

        st_mostra: begin
          if (timer_reg == TIMER_ON_LAST) begin
            timer_reg <= '0;
            if (endereco_reg == limite_reg) begin
              // Last address: no increment, so the address never wraps.
              estado_reg <= st_fim;
            end else begin
`ifdef SEQ_GAP_EN
              estado_reg <= st_apaga;
`else
              endereco_reg <= endereco_reg + 4'd1;
              estado_reg   <= st_proximo;
`endif
            end
          end else if (timer_reg != TIMER_SAT) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

`ifdef SEQ_GAP_EN
        st_apaga: begin
          if (timer_reg == TIMER_OFF_LAST) begin
            timer_reg    <= '0;
            endereco_reg <= endereco_reg + 4'd1;
            estado_reg   <= st_proximo;
          end else if (timer_reg != TIMER_SAT) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
`endif

        st_proximo: begin
          timer_reg  <= '0;
          estado_reg <= st_mostra;
        end

        st_fim: begin
          estado_reg <= st_inicial;
        end

        default: begin
          estado_reg <= st_inicial;
        end
      endcase
    end
  end

  // Status outputs decode the state register only; 'leds' is deliberately
  // combinational from state and 'dado' so it tracks the memory word.
  assign endereco  = endereco_reg;
  assign exibindo  = (estado_reg != st_inicial);
  assign pronto    = (estado_reg == st_fim);
  assign db_estado = estado_reg;
  assign leds      = (estado_reg == st_mostra) ? dado : 4'b0000;

endmodule

// File: tb/tb_mostra_sequencia.sv
// -----------------------------------------------------------------------------
// tb_mostra_sequencia
//
// Drives runs of mostra_sequencia (T_ON=3, T_OFF=2) against a synchronous-read
// memory model. For each vector the expected per-cycle outputs are pushed into
// a queue when 'iniciar' is driven and popped/compared every cycle; the pronto
// cycle is also checked against hand-computed constants. Hand-written
// sequences cover reset-state and asynchronous mid-run reset.
// -----------------------------------------------------------------------------
module tb_mostra_sequencia;

  localparam int T_ON  = 3;
  localparam int T_OFF = 2;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  mostra_sequencia #(
    .T_ON  (T_ON),
    .T_OFF (T_OFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .limite    (limite),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memory, one cycle of latency.
  logic [3:0] mem [16];
  always @(posedge clock) dado <= mem[endereco];

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] leds;
    logic [3:0] ende;
    logic       pronto;
    logic       exib;
  } exp_t;

  typedef struct {
    logic [3:0]  lim;
    logic [63:0] img;
    int          fim_nogap;
    int          fim_gap;
    bit          disturb;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs [5];
  int   checks;
  int   errors;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int st, input int lv, input int ende, input int pr, input int ex);
    exp_t e;
    e.st     = 4'(st);
    e.leds   = 4'(lv);
    e.ende   = 4'(ende);
    e.pronto = 1'(pr);
    e.exib   = 1'(ex);
    exp_q.push_back(e);
  endtask

  // Expected trace from cycle 1 (preparacao) to a few idle cycles after fim.
  task automatic build_trace(input logic [3:0] lim, input logic [63:0] img);
    int l;
    l = int'(lim);
    push_exp(1, 0, 0, 0, 1);
    for (int a = 0; a <= l; a++) begin
      for (int t = 0; t < T_ON; t++) push_exp(2, int'(img[4*a +: 4]), a, 0, 1);
      if (a < l) begin
`ifdef SEQ_GAP_EN
        for (int t = 0; t < T_OFF; t++) push_exp(3, 0, a, 0, 1);
`endif
        push_exp(4, 0, a + 1, 0, 1);
      end
    end
    push_exp(5, 0, l, 1, 1);
    for (int t = 0; t < 3; t++) push_exp(0, 0, l, 0, 0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    int   cyc;
    int   pronto_n;
    int   pronto_cyc;
    int   exp_fim;
    v = vecs[idx];
`ifdef SEQ_GAP_EN
    exp_fim = v.fim_gap;
`else
    exp_fim = v.fim_nogap;
`endif
    for (int i = 0; i < 16; i++) mem[i] = v.img[4*i +: 4];
    limite  = v.lim;
    iniciar = 1'b1;
    build_trace(v.lim, v.img);
    cyc        = 0;
    pronto_n   = 0;
    pronto_cyc = -1;
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1) iniciar = 1'b0;
      if (v.disturb && cyc == 3) begin
        iniciar = 1'b1;
        limite  = 4'd9;
      end
      if (v.disturb && cyc == 4) iniciar = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("v%0d_c%0d_estado", idx, cyc), int'(db_estado), int'(e.st));
      check($sformatf("v%0d_c%0d_leds", idx, cyc), int'(leds), int'(e.leds));
      check($sformatf("v%0d_c%0d_endereco", idx, cyc), int'(endereco), int'(e.ende));
      check($sformatf("v%0d_c%0d_pronto", idx, cyc), int'(pronto), int'(e.pronto));
      check($sformatf("v%0d_c%0d_exibindo", idx, cyc), int'(exibindo), int'(e.exib));
      if (pronto) begin
        pronto_n++;
        pronto_cyc = cyc;
      end
    end
    check($sformatf("v%0d_pronto_count", idx), pronto_n, 1);
    check($sformatf("v%0d_pronto_cycle", idx), pronto_cyc, exp_fim);
    $display("vec %0d limite=%0d pronto_cycle=%0d expected=%0d", idx, v.lim, pronto_cyc, exp_fim);
  endtask

  initial begin
    int found;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    iniciar = 1'b0;
    limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;

    //             lim    img                     nogap gap disturb
    vecs[0] = '{4'd0,  64'h0000000000000001,  5,  5, 1'b0};
    vecs[1] = '{4'd3,  64'h0000000000008421, 17, 23, 1'b0};
    vecs[2] = '{4'd2,  64'h0000000000000555, 13, 17, 1'b0};
    vecs[3] = '{4'd2,  64'hFFFFFFFFFFFFFA69, 13, 17, 1'b1};
    vecs[4] = '{4'd15, 64'h7F3E9A5C6B2D8E41, 65, 95, 1'b0};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_estado", int'(db_estado), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_endereco", int'(endereco), 0);
    check("rst_exibindo", int'(exibindo), 0);
    check("rst_pronto", int'(pronto), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_estado", int'(db_estado), 0);
    $display("reset state checked");

    for (int v = 0; v < 5; v++) run_vec(v);

    // Asynchronous reset during 'mostra' of address 2.
    for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
    limite  = 4'd4;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (db_estado == 4'd2 && endereco == 4'd2) found = 1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    check("areset_reach_addr2", found, 1);
    check("areset_pre_leds", int'(leds), 3);
    #2;
    reset = 1'b1;
    #1;
    check("areset_leds", int'(leds), 0);
    check("areset_endereco", int'(endereco), 0);
    check("areset_exibindo", int'(exibindo), 0);
    check("areset_estado", int'(db_estado), 0);
    check("areset_pronto", int'(pronto), 0);
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    check("areset_hold_estado", int'(db_estado), 0);
    check("areset_hold_pronto", int'(pronto), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("areset_restart_estado", int'(db_estado), 1);
    iniciar = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clock);
      #1;
      if (pronto) found = 1;
    end
    check("areset_restart_pronto", found, 1);
    check("areset_restart_endereco", int'(endereco), 4);
    $display("async reset sequence checked");

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
